// File: rtl/shift_rotate_sequencer.sv
// Multi-cycle 32-bit shift/rotate unit: steps an accumulator one bit per clock (SHR/SHRA/SHL/ROR/ROL).
// Define SHIFT_SEQ_FAST_STEP_EN to take 4-bit steps while at least four steps remain.
module shift_rotate_sequencer #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] amount,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_SHR  = 3'd0;
    localparam logic [2:0] OP_SHRA = 3'd1;
    localparam logic [2:0] OP_SHL  = 3'd2;
    localparam logic [2:0] OP_ROR  = 3'd3;
    localparam logic [2:0] OP_ROL  = 3'd4;

    state_t            state_q;
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] acc_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [2:0]        op_q;
    logic              done_q;
    logic [DATA_W-1:0] result_q;

    function automatic logic [DATA_W-1:0] step1(input logic [DATA_W-1:0] a, input logic [2:0] o);
        case (o)
            OP_SHR:  step1 = {1'b0, a[DATA_W-1:1]};
            OP_SHRA: step1 = {a[DATA_W-1], a[DATA_W-1:1]};
            OP_SHL:  step1 = {a[DATA_W-2:0], 1'b0};
            OP_ROR:  step1 = {a[0], a[DATA_W-1:1]};
            OP_ROL:  step1 = {a[DATA_W-2:0], a[DATA_W-1]};
            default: step1 = a;
        endcase
    endfunction

`ifdef SHIFT_SEQ_FAST_STEP_EN
    function automatic logic [DATA_W-1:0] step4(input logic [DATA_W-1:0] a, input logic [2:0] o);
        case (o)
            OP_SHR:  step4 = {4'b0000, a[DATA_W-1:4]};
            OP_SHRA: step4 = {{4{a[DATA_W-1]}}, a[DATA_W-1:4]};
            OP_SHL:  step4 = {a[DATA_W-5:0], 4'b0000};
            OP_ROR:  step4 = {a[3:0], a[DATA_W-1:4]};
            OP_ROL:  step4 = {a[DATA_W-5:0], a[DATA_W-1:DATA_W-4]};
            default: step4 = a;
        endcase
    endfunction

    // Next accumulator/count for one RUN cycle (4-bit stride while possible)
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (cnt_q >= 5'd4) begin
            acc_d = step4(acc_q, op_q);
            cnt_d = cnt_q - 5'd4;
        end else begin
            acc_d = step1(acc_q, op_q);
            cnt_d = cnt_q - 5'd1;
        end
    end
`else
    // Next accumulator/count for one RUN cycle
    always_comb begin
        acc_d = step1(acc_q, op_q);
        cnt_d = cnt_q - 5'd1;
    end
`endif

    // Sequencer FSM with registered done/result; start is only honoured in IDLE
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            op_q     <= 3'd0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        acc_q   <= in_data;
                        cnt_q   <= amount[CNT_W-1:0];
                        op_q    <= op;
                        state_q <= S_RUN;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (cnt_q != 5'd0) begin
                        acc_q  <= acc_d;
                        cnt_q  <= cnt_d;
                        done_q <= 1'b0;
                    end else begin
                        result_q <= acc_q;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = done_q;
    assign result = result_q;

endmodule
